// File: rtl/icache_pkg.sv
// Shared CPU types for the instruction cache.
//   word_t          32-bit machine word
//   icache_frame_t  one cache frame {valid, tag, data}
//   icachef_t       instruction address split {tag, idx, bytoff}
//   ic_state_t      cache controller state {IDLE, FETCH}
// The cache geometry (IC_SETS) lives here so the frame and address-split
// types share the widths that the cache module is built with.
package icache_pkg;

    typedef logic [31:0] word_t;

    localparam int IC_SETS  = 16;
    localparam int IC_IDX   = $clog2(IC_SETS);
    localparam int IC_TAG_W = 30 - IC_IDX;

    typedef struct packed {
        logic                valid;
        logic [IC_TAG_W-1:0] tag;
        word_t               data;
    } icache_frame_t;

    typedef struct packed {
        logic [IC_TAG_W-1:0] tag;
        logic [IC_IDX-1:0]   idx;
        logic [1:0]          bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } ic_state_t;

endpackage

// File: rtl/icache_if.sv
// Bus interfaces around the instruction cache.
//   icache_if      fetch-stage request: imemREN/imemaddr from fetch,
//                  ihit/imemload back from the cache.
//                  master = fetch stage, slave = cache.
//   icache_mem_if  fill path to the memory arbiter: iREN/iaddr from the
//                  cache, iwait/iload back from memory.
//                  master = cache, slave = memory controller.
interface icache_if;
    import icache_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    modport master (output imemREN, output imemaddr, input  ihit, input  imemload);
    modport slave  (input  imemREN, input  imemaddr, output ihit, output imemload);
endinterface

interface icache_mem_if;
    import icache_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport master (output iREN, output iaddr, input  iwait, input  iload);
    modport slave  (input  iREN, input  iaddr, output iwait, output iload);
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with single-word fills.
// Hits are answered combinationally in IDLE; a miss latches the word
// address and runs one fill from memory in FETCH, after which the same
// address is answered as a hit.
// Ports:
//   CLK      system clock, rising edge
//   nRST     asynchronous active-low reset
//   fetch    icache_if.slave     (imemREN, imemaddr -> ihit, imemload)
//   mem      icache_mem_if.master (iREN, iaddr <- iwait, iload)
//   hitcnt   number of hits served (wraps)
//   misscnt  number of fills started (wraps)
module icache
    import icache_pkg::*;
#(
    parameter int SETS = IC_SETS   // must match the package geometry
) (
    input  logic  CLK,
    input  logic  nRST,
    icache_if.slave      fetch,
    icache_mem_if.master mem,
    output word_t hitcnt,
    output word_t misscnt
);

    icache_frame_t frames [SETS];
    ic_state_t     state;
    word_t         missaddr;
    logic          ren;

    icachef_t      req;
    icachef_t      fill;
    icache_frame_t sel;
    logic          hit;
    logic          unused_bytoff;

    assign req  = icachef_t'(fetch.imemaddr);
    assign fill = icachef_t'(missaddr);
    assign sel  = frames[req.idx];

    // Instruction fetch is word granular; the byte offset never matters.
    assign unused_bytoff = ^{req.bytoff, fill.bytoff};

    assign hit = (state == IDLE) && fetch.imemREN && sel.valid && (sel.tag == req.tag);

    assign fetch.ihit     = hit;
    assign fetch.imemload = sel.data;

    // Fill request comes straight from registers so it cannot glitch
    // while the fill is in progress.
    assign mem.iREN  = ren;
    assign mem.iaddr = missaddr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            ren      <= 1'b0;
            missaddr <= '0;
            hitcnt   <= '0;
            misscnt  <= '0;
            for (int i = 0; i < SETS; i++) begin
                frames[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        hitcnt <= hitcnt + 32'd1;
                    end else if (fetch.imemREN) begin
                        missaddr <= {req.tag, req.idx, 2'b00};
                        misscnt  <= misscnt + 32'd1;
                        ren      <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    // The latched miss address drives the write; the live
                    // fetch address may already have moved on.
                    if (!mem.iwait) begin
                        frames[fill.idx] <= {1'b1, fill.tag, mem.iload};
                        ren              <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios followed by a randomized run
// checked by a scoreboard against a line-level reference cache model.
module tb_icache;
    import icache_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST = 1'b0;
    word_t hitcnt;
    word_t misscnt;

    icache_if     fif ();
    icache_mem_if mif ();

    icache #(.SETS(16)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .fetch   (fif),
        .mem     (mif),
        .hitcnt  (hitcnt),
        .misscnt (misscnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image keyed by word address, and one cached
    // word address per set.
    typedef struct {
        word_t data;
        bit    hit;
    } exp_t;

    exp_t  exp_q [$];
    word_t mem_img [word_t];
    bit    mvalid [16];
    word_t mline  [16];
    int    exp_hit  = 0;
    int    exp_miss = 0;
    word_t cur_req  = '0;
    bit    mon_en   = 1'b0;
    bit    auto_mem = 1'b0;
    int    wc       = 0;
    bit    in_fill  = 1'b0;
    int    wait_left = 0;

    function automatic word_t mem_word(input word_t line);
        if (!mem_img.exists(line)) mem_img[line] = $urandom;
        return mem_img[line];
    endfunction

    // Monitor: every presented hit is matched to the oldest expected access.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (fif.ihit) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_hit", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", fif.imemload, e.data);
                        check("rd_latency", e.hit ? 32'(wc == 0) : 32'(wc >= 2), 32'd1);
                    end
                    wc = 0;
                end else if (fif.imemREN) begin
                    wc++;
                end
            end
        end
    end

    // Memory responder with random wait states.
    initial begin
        forever begin
            @(negedge CLK);
            if (auto_mem) begin
                if (mif.iREN) begin
                    if (!in_fill) begin
                        in_fill   = 1'b1;
                        wait_left = $urandom_range(0, 3);
                        check("fill_addr", mif.iaddr, cur_req);
                    end
                    if (wait_left > 0) begin
                        mif.iwait = 1'b1;
                        mif.iload = $urandom;
                        wait_left--;
                    end else begin
                        mif.iwait = 1'b0;
                        mif.iload = mem_img.exists(mif.iaddr >> 2) ? mem_img[mif.iaddr >> 2] : 32'h0;
                        in_fill   = 1'b0;
                    end
                end else begin
                    mif.iwait = 1'b1;
                    in_fill   = 1'b0;
                end
            end
        end
    end

    // Directed miss: detect, hold iwait high for 'waits' cycles, return d.
    task automatic dmiss(input word_t a, input word_t d, input int waits);
        @(posedge CLK); #1;
        fif.imemREN = 1'b1; fif.imemaddr = a; mif.iwait = 1'b1;
        @(negedge CLK);
        check("miss_ihit", fif.ihit, 32'd0);
        for (int w = 0; w <= waits; w++) begin
            @(posedge CLK); #1;
            mif.iwait = (w < waits);
            mif.iload = (w < waits) ? 32'hdead_beef : d;
            @(negedge CLK);
            check("fill_iren", mif.iREN, 32'd1);
            check("fill_iaddr", mif.iaddr, a & ~32'h3);
            check("fill_noihit", fif.ihit, 32'd0);
        end
        @(posedge CLK); #1;
        mif.iwait = 1'b1;
        @(negedge CLK);
        check("fill_ihit", fif.ihit, 32'd1);
        check("fill_data", fif.imemload, d);
    endtask

    initial begin
        word_t h0;
        word_t a;
        bit    got;
        int    li;
        word_t line;
        bit    ishit;

        fif.imemREN = 1'b0; fif.imemaddr = '0;
        mif.iwait = 1'b1;   mif.iload = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ihit", fif.ihit, 32'd0);
        check("rst_iren", mif.iREN, 32'd0);
        check("rst_iaddr", mif.iaddr, 32'd0);
        check("rst_imemload", fif.imemload, 32'd0);
        check("rst_hitcnt", hitcnt, 32'd0);
        check("rst_misscnt", misscnt, 32'd0);
        @(posedge CLK); #1 nRST = 1'b1;

        // First miss on 0x40 with two wait cycles
        dmiss(32'h40, 32'h2001_0005, 2);
        check("miss1_cnt", misscnt, 32'd1);

        // Five hit cycles on 0x40
        h0 = hitcnt;
        for (int i = 0; i < 5; i++) begin
            check("reread_ihit", fif.ihit, 32'd1);
            check("reread_iren", mif.iREN, 32'd0);
            @(posedge CLK); #1;
            @(negedge CLK);
        end
        check("reread_hitcnt", hitcnt, h0 + 32'd5);

        // Unaligned address returns the aligned word
        @(posedge CLK); #1 fif.imemaddr = 32'h43;
        @(negedge CLK);
        check("unaligned_ihit", fif.ihit, 32'd1);
        check("unaligned_data", fif.imemload, 32'h2001_0005);

        // Conflict: 0x80 evicts 0x40 and vice versa
        dmiss(32'h80, 32'h1111_2222, 0);
        dmiss(32'h40, 32'h2001_0005, 1);
        check("conflict_misscnt", misscnt, 32'd3);

        // Address changes mid-fill: the latched 0x44 is filled
        @(posedge CLK); #1 fif.imemaddr = 32'h44;
        @(negedge CLK);
        check("mid_miss", fif.ihit, 32'd0);
        @(posedge CLK); #1 fif.imemaddr = 32'h100; mif.iwait = 1'b1;
        @(negedge CLK);
        check("mid_iaddr0", mif.iaddr, 32'h44);
        @(posedge CLK); #1 mif.iwait = 1'b0; mif.iload = 32'h3333_4444;
        @(negedge CLK);
        check("mid_iaddr1", mif.iaddr, 32'h44);
        @(posedge CLK); #1 mif.iwait = 1'b1;
        @(negedge CLK);
        check("mid_newmiss", fif.ihit, 32'd0);
        @(posedge CLK); #1 mif.iwait = 1'b0; mif.iload = 32'h5555_6666;
        @(negedge CLK);
        check("mid_iaddr2", mif.iaddr, 32'h100);
        @(posedge CLK); #1 mif.iwait = 1'b1;
        @(negedge CLK);
        check("mid_100_hit", fif.ihit, 32'd1);
        check("mid_100_data", fif.imemload, 32'h5555_6666);
        @(posedge CLK); #1 fif.imemaddr = 32'h44;
        @(negedge CLK);
        check("mid_44_hit", fif.ihit, 32'd1);
        check("mid_44_data", fif.imemload, 32'h3333_4444);
        check("mid_misscnt", misscnt, 32'd5);

        // Reset in the middle of a fill
        @(posedge CLK); #1 fif.imemaddr = 32'h80;
        @(posedge CLK); #1 mif.iwait = 1'b1;
        @(negedge CLK);
        check("rstfill_iren_before", mif.iREN, 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("rstfill_iren", mif.iREN, 32'd0);
        check("rstfill_iaddr", mif.iaddr, 32'd0);
        @(posedge CLK); #1 nRST = 1'b1; fif.imemaddr = 32'h40;
        @(negedge CLK);
        check("rstfill_40_miss", fif.ihit, 32'd0);
        check("rstfill_hitcnt", hitcnt, 32'd0);
        check("rstfill_misscnt", misscnt, 32'd0);
        @(posedge CLK); #1 nRST = 1'b0; fif.imemREN = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;

        // Randomized run against the reference model
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        mon_en = 1'b1; auto_mem = 1'b1;
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom);
            line  = a >> 2;
            li    = int'(line % 16);
            ishit = mvalid[li] && (mline[li] == line);
            if (!ishit) begin
                mvalid[li] = 1'b1;
                mline[li]  = line;
                exp_miss++;
            end
            exp_hit++;
            exp_q.push_back('{data: mem_word(line), hit: ishit});
            @(posedge CLK); #1;
            cur_req = a & ~32'h3;
            fif.imemREN = 1'b1; fif.imemaddr = a;
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge CLK);
                if (fif.ihit) begin
                    got = 1'b1;
                    break;
                end
            end
            check("req_done", 32'(got), 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
                fif.imemREN = 1'b0; fif.imemaddr = $urandom;
                repeat ($urandom_range(0, 2)) @(posedge CLK);
            end
        end
        @(posedge CLK); #1 fif.imemREN = 1'b0;
        @(negedge CLK);
        check("final_hitcnt", hitcnt, 32'(exp_hit));
        check("final_misscnt", misscnt, 32'(exp_miss));
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
